// File: rtl/maxnet_pkg.sv
// rtl/maxnet_pkg.sv - shared fixed-point helpers and FSM state encoding for the MaxNet weight streamer
package maxnet_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  // Fixed-point +1.0 for the given number of fractional bits.
  function automatic int one_fx(input int frac);
    return 1 << frac;
  endfunction

  // Two's-complement negation of a non-negative magnitude, truncated to width bits.
  function automatic int neg_fx(input int eps, input int width);
    int mask;
    mask = (1 << width) - 1;
    return (~eps + 1) & mask;
  endfunction

endpackage

// File: rtl/maxnet_weight_streamer_if.sv
// rtl/maxnet_weight_streamer_if.sv - weight stream bus between the streamer and the MAC datapath
interface maxnet_weight_streamer_if #(
  parameter int WIDTH = 5,
  parameter int IW    = 2
);
  logic [WIDTH-1:0] w_data;
  logic [IW-1:0]    w_row;
  logic [IW-1:0]    w_col;
  logic             w_valid;
  logic             w_ready;
  logic             w_last_col;
  logic             w_last;

  modport master (
    output w_data, w_row, w_col, w_valid, w_last_col, w_last,
    input  w_ready
  );

  modport slave (
    input  w_data, w_row, w_col, w_valid, w_last_col, w_last,
    output w_ready
  );
endinterface

// File: rtl/maxnet_idx_counter.sv
// rtl/maxnet_idx_counter.sv - row/col walker with load, wrap at N-1 and end-of-row/end-of-stream flags
module maxnet_idx_counter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          full_mode,
  input  logic [IW-1:0] load_row,
  input  logic [IW-1:0] load_col,
  input  logic          en,
  output logic [IW-1:0] row,
  output logic [IW-1:0] col,
  output logic          last_col,
  output logic          last
);
  localparam logic [IW-1:0] MAX_IDX = IW'(N - 1);

  logic full_q;

  // Load a new start point, otherwise step col and carry into row only when walking the whole matrix.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row    <= '0;
      col    <= '0;
      full_q <= 1'b0;
    end else if (load) begin
      row    <= load_row;
      col    <= load_col;
      full_q <= full_mode;
    end else if (en) begin
      if (col == MAX_IDX) begin
        col <= '0;
        if (full_q) row <= (row == MAX_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last_col = (col == MAX_IDX);
  assign last     = last_col && (!full_q || (row == MAX_IDX));

endmodule

// File: rtl/maxnet_weight_streamer.sv
// rtl/maxnet_weight_streamer.sv - generates and streams the N x N MaxNet weight matrix (full or one row)
module maxnet_weight_streamer
  import maxnet_pkg::*;
#(
  parameter int N         = 4,
  parameter int WIDTH     = 5,
  parameter int FRAC      = 3,
  parameter int EPS_RESET = 2,
  parameter int IW        = $clog2(N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   eps_wr,
  input  logic [WIDTH-2:0]       eps_in,
  input  logic                   start,
  input  logic                   row_mode,
  input  logic [IW-1:0]          row_idx,
  maxnet_weight_streamer_if.master wb,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);
  localparam logic [0:0]       S_IDLE   = ST_IDLE;
  localparam logic [0:0]       S_STREAM = ST_STREAM;
  localparam logic [IW:0]      N_V      = (IW + 1)'(N);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(one_fx(FRAC));

  logic [0:0]       state;
  logic [WIDTH-2:0] eps_reg;
  logic             streaming;
  logic             row_ok;
  logic             accept;
  logic             hs;
  logic [IW-1:0]    cnt_row;
  logic [IW-1:0]    cnt_col;
  logic             cnt_last_col;
  logic             cnt_last;
  logic [WIDTH-1:0] neg_w;
  logic [WIDTH-1:0] weight;

  assign streaming = (state == S_STREAM);
  assign row_ok    = !row_mode || ({1'b0, row_idx} < N_V);
  assign accept    = (state == S_IDLE) && start && row_ok;
  assign hs        = streaming && wb.w_ready;

  maxnet_idx_counter #(.N(N), .IW(IW)) u_idx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .full_mode (!row_mode),
    .load_row  (row_mode ? row_idx : '0),
    .load_col  ('0),
    .en        (hs),
    .row       (cnt_row),
    .col       (cnt_col),
    .last_col  (cnt_last_col),
    .last      (cnt_last)
  );

  // Controller FSM; epsilon is only writable in IDLE so one stream always sees a single value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      eps_reg <= (WIDTH - 1)'(EPS_RESET);
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (eps_wr) eps_reg <= eps_in;
          if (start) begin
            if (row_ok) state <= S_STREAM;
            else        err   <= 1'b1;
          end
        end
        S_STREAM: begin
          if (hs && cnt_last) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign neg_w  = WIDTH'(neg_fx(int'(eps_reg), WIDTH));
  assign weight = (cnt_row == cnt_col) ? ONE_W : neg_w;

  // Bus fields are zero whenever no word is on offer, matching the reset image.
  assign wb.w_valid    = streaming;
  assign wb.w_data     = streaming ? weight : '0;
  assign wb.w_row      = streaming ? cnt_row : '0;
  assign wb.w_col      = streaming ? cnt_col : '0;
  assign wb.w_last_col = streaming && cnt_last_col;
  assign wb.w_last     = streaming && cnt_last;
  assign busy          = streaming;

endmodule

// File: tb/tb_maxnet_weight_streamer.sv
// tb/tb_maxnet_weight_streamer.sv - scoreboard bench for maxnet_weight_streamer
module tb_maxnet_weight_streamer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       eps_wr;
  logic [3:0] eps_in;
  logic       start;
  logic       row_mode;
  logic [1:0] row_idx;
  logic       busy, done, err;

  logic       start5, row_mode5;
  logic [2:0] row_idx5;
  logic       busy5, done5, err5;

  int checks   = 0;
  int failures = 0;
  logic [10:0] sb[$];

  maxnet_weight_streamer_if #(.WIDTH(5), .IW(2)) wif ();
  maxnet_weight_streamer_if #(.WIDTH(5), .IW(3)) wif5 ();

  maxnet_weight_streamer #(.N(4), .WIDTH(5), .FRAC(3), .EPS_RESET(2)) dut (
    .clk(clk), .rst_n(rst_n), .eps_wr(eps_wr), .eps_in(eps_in), .start(start),
    .row_mode(row_mode), .row_idx(row_idx), .wb(wif), .busy(busy), .done(done), .err(err)
  );

  maxnet_weight_streamer #(.N(5), .WIDTH(5), .FRAC(3), .EPS_RESET(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .eps_wr(1'b0), .eps_in(4'd0), .start(start5),
    .row_mode(row_mode5), .row_idx(row_idx5), .wb(wif5), .busy(busy5), .done(done5), .err(err5)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_outs();
    return {wif.w_data, wif.w_row, wif.w_col, wif.w_valid, wif.w_last_col, wif.w_last, busy, done, err};
  endfunction

  // Expected word: {data, row, col, last_col, last}.
  task automatic push_expected(input bit full, input int r0, input int eps);
    int rlo, rhi;
    logic [4:0] d;
    rlo = full ? 0 : r0;
    rhi = full ? 3 : r0;
    for (int r = rlo; r <= rhi; r++)
      for (int c = 0; c < 4; c++) begin
        d = (r == c) ? 5'b01000 : 5'(-eps);
        sb.push_back({d, 2'(r), 2'(c), 1'(c == 3), 1'(full ? (r == 3 && c == 3) : (c == 3))});
      end
  endtask

  task automatic run_stream(input bit rm, input logic [1:0] ri, input bit bp, input string tag);
    int hs, nexp;
    logic [10:0] obs, prev, exp;
    logic held;
    nexp = sb.size();
    start = 1'b1; row_mode = rm; row_idx = ri;
    tick();
    start = 1'b0;
    check({tag, "_busy_start"}, busy, 1);
    hs = 0; held = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 200 && sb.size() > 0; cyc++) begin
      obs = {wif.w_data, wif.w_row, wif.w_col, wif.w_last_col, wif.w_last};
      check({tag, "_valid"}, wif.w_valid, 1);
      if (held) check({tag, "_stable"}, obs, prev);
      wif.w_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (wif.w_valid && wif.w_ready) begin
        exp = sb.pop_front();
        check({tag, "_word"}, obs, exp);
        hs++;
        held = 1'b0;
      end else begin
        held = wif.w_valid;
        prev = obs;
      end
      tick();
    end
    wif.w_ready = 1'b0;
    check({tag, "_timeout"}, sb.size(), 0);
    sb.delete();
    check({tag, "_handshakes"}, hs, nexp);
    check({tag, "_done_pulse"}, {done, busy, wif.w_valid}, 3'b100);
    tick();
    check({tag, "_done_clear"}, done, 0);
  endtask

  initial begin
    rst_n = 1'b0; eps_wr = 1'b0; eps_in = '0; start = 1'b0; row_mode = 1'b0; row_idx = '0;
    start5 = 1'b0; row_mode5 = 1'b0; row_idx5 = '0;
    wif.w_ready = 1'b0; wif5.w_ready = 1'b0;
    tick(); tick();
    check("reset_outs", all_outs(), 0);
    rst_n = 1'b1;
    tick();
    check("idle_outs", all_outs(), 0);

    push_expected(1, 0, 2);
    run_stream(0, 0, 0, "full");

    push_expected(1, 0, 2);
    run_stream(0, 0, 1, "backpressure");

    push_expected(0, 2, 2);
    run_stream(1, 2, 0, "row2");

    eps_wr = 1'b1; eps_in = 4'd1;
    tick();
    eps_wr = 1'b0;
    push_expected(1, 0, 1);
    run_stream(0, 0, 0, "eps1");

    eps_wr = 1'b1; eps_in = 4'd0;
    tick();
    eps_wr = 1'b0;
    push_expected(1, 0, 0);
    run_stream(0, 0, 0, "eps0");

    start5 = 1'b1; row_mode5 = 1'b1; row_idx5 = 3'd5;
    tick();
    start5 = 1'b0;
    check("rej_err", err5, 1);
    check("rej_busy", {busy5, wif5.w_valid}, 0);
    tick();
    check("rej_err_clear", {err5, busy5, wif5.w_valid}, 0);

    start = 1'b1; row_mode = 1'b0; row_idx = '0;
    tick();
    start = 1'b0;
    wif.w_ready = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", all_outs(), 0);
    wif.w_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    push_expected(1, 0, 2);
    run_stream(0, 0, 0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/maxnet_weight_streamer.md
Name: maxnet_weight_streamer

Overview:
- Parametrised successor to the fixed 4x4 MaxNet weight buffer.
- Generates the N x N MaxNet weight matrix on the fly: diagonal = +1.0, off-diagonal = -epsilon. Epsilon is run-time programmable.
- Streams weights to the MAC datapath over a valid/ready handshake, either the full matrix (row-major) or one selected row.
- Sits between the controller (start/mode) and the neuron update datapath.

Parameters:
- N, 4, neuron count (matrix is N x N); N >= 2.
- WIDTH, 5, weight word width, signed two's complement fixed point.
- FRAC, 3, fractional bits; FRAC <= WIDTH-2, so ONE = 1<<FRAC is representable.
- EPS_RESET, 2, reset value of the epsilon magnitude in LSBs (2 = 0.25 at FRAC=3).
- IW, $clog2(N), row/column index width (derived; do not override).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- eps_wr  in  1  load epsilon register from eps_in
- eps_in  in  WIDTH-1  unsigned epsilon magnitude in LSBs
- start  in  1  start request; sampled only in IDLE
- row_mode  in  1  0 = full matrix, 1 = single row; sampled with start
- row_idx  in  IW  row to stream when row_mode=1; sampled with start
- w_data  out  WIDTH  weight W[row][col]
- w_row  out  IW  row index of w_data
- w_col  out  IW  column index of w_data
- w_valid  out  1  w_data/w_row/w_col valid
- w_ready  in  1  consumer accepts the word
- w_last_col  out  1  current word is column N-1
- w_last  out  1  current word is the final word of the stream
- busy  out  1  high in STREAM
- done  out  1  one-cycle pulse after the final handshake
- err  out  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (async assert, sync release):
  - State IDLE.
  - Outputs w_data, w_row, w_col, w_valid, w_last_col, w_last, busy, done and err all 0.
  - eps_reg = EPS_RESET.
- Weight value:
  - W = ONE (1<<FRAC) when row == col.
  - Otherwise W = two's-complement negation of {1'b0, eps_reg}, i.e. ~{0,eps}+1 truncated to WIDTH bits.
  - eps_reg = 0 gives an off-diagonal word of 0.
  - All outputs come from registers; there are no combinational paths from inputs to outputs.
- Epsilon load:
  - eps_wr in IDLE loads eps_reg at the next edge.
  - eps_wr while busy is ignored; the matrix stays consistent within one stream.
  - eps_wr together with an accepted start: the load takes effect, and the stream uses the new epsilon.
- FSM states: IDLE, STREAM.
- IDLE -> STREAM:
  - Condition: start=1 and (row_mode=0 or row_idx < N).
  - Next cycle: w_valid=1, busy=1, first word presented (latency 1).
  - Full-matrix mode starts at row 0; row mode starts at row row_idx. Both start at column 0.
- IDLE start rejected:
  - Condition: start=1, row_mode=1, row_idx >= N.
  - err pulses for one cycle; the FSM stays in IDLE.
- STREAM advance:
  - Fires only on w_valid & w_ready.
  - col increments; at col = N-1, col wraps to 0 and row increments (full mode only).
  - With w_ready=0, every output holds stable (no drops, no duplicates).
- Stream length and flags:
  - Full mode: N*N words, with w_last on (N-1, N-1).
  - Row mode: N words, with w_last on (row_idx, N-1).
  - w_last_col is asserted on every word with col = N-1.
- Final handshake (w_last & w_ready):
  - Next cycle: w_valid=0, busy=0, done=1 for one cycle, state IDLE.
  - A start in the done cycle is accepted.
- start while busy is ignored; it causes no err.
- Reset mid-stream: immediate abort to the reset values. No done pulse; any partial stream is discarded by the consumer on reset.

Decomposition:
- Shared package maxnet_pkg holds:
  - function one_fx(FRAC);
  - function neg_fx(eps, WIDTH);
  - FSM state enum for IDLE and STREAM.
- One sub-module, maxnet_idx_counter: a row/col counter with enable, load(row,col), wrap at N-1, and last_col/last flags.
- The FSM and weight mux stay in the top-level module.

Test Plan:
All scenarios use N=4, WIDTH=5, FRAC=3, default eps=2.
- Full stream, w_ready held high → 16 words, row-major:
  - Diagonal (0,0), (1,1), (2,2), (3,3) = 01000; all other words = 11110.
  - w_last_col on cols 3; w_last on the 16th word.
  - done pulses exactly one cycle later.
- Backpressure: w_ready toggles 1,0,0,1 repeatedly → sequence identical to the first scenario; outputs stable during every w_ready=0 cycle; exactly 16 handshakes.
- eps load in IDLE:
  - eps_in=1, then full stream → off-diagonal words = 11111, diagonal = 01000.
  - Then eps_in=0 → off-diagonal words = 00000.
- Row mode, row_idx=2 → 11110, 11110, 01000, 11110 with w_row=2; w_last on col 3; done follows.
- Row mode, row_idx=5 (IW=2, so drive N via an N=5 build, or inject via a wider IW test build) → err pulse, busy stays 0, no w_valid.
- Reset mid-stream: assert rst_n=0 after the 6th handshake → all outputs 0 immediately, eps_reg=2.
  - A new start after reset streams from (0,0).
